// File: rtl/sevenseg_scan_ctrl.sv
// Purpose : scans a 4-digit common-anode 7-seg panel through one shared hex encoder,
//           with frame-aligned value commit, inter-digit blanking and zero suppression.
// Latency : an/hex_out registered; a value accepted in frame N is shown from frame N+1.
// Backpr. : ready=0 while a committed value is pending; load is ignored until the next
//           frame boundary commits it and ready returns high.
// Ports   : clk, rst_n (async active-low); load/data_in/ready value handshake;
//           lz_en, blank_mask live suppression controls; hex_out to encoder; an anodes (active-low).
module sevenseg_scan_ctrl #(
  parameter int SLOT_CYCLES  = 100000,
  parameter int BLANK_CYCLES = 1000,
  parameter int CNT_W        = 17
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [15:0] data_in,
  input  logic        lz_en,
  input  logic [3:0]  blank_mask,
  output logic        ready,
  output logic [3:0]  hex_out,
  output logic [3:0]  an
);

  typedef enum logic {BLANK, ON} state_t;

  localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(SLOT_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       idx;
  logic [15:0]      active;
  logic [15:0]      shadow;
  logic             pending;

  logic             z3, z2, z1;
  logic [3:0]       supp;
  logic [3:0]       nib;

  // Leading-zero chain: digit i is a leading zero when nibbles i..3 are all zero.
  // Digit 0 never takes part, so a zero value still shows a single 0.
  always_comb begin
    z3   = (active[15:12] == 4'h0);
    z2   = z3 && (active[11:8] == 4'h0);
    z1   = z2 && (active[7:4] == 4'h0);
    supp = blank_mask | ({z3, z2, z1, 1'b0} & {4{lz_en}});
    nib  = active[{idx, 2'b00} +: 4];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= BLANK;
      cnt     <= '0;
      idx     <= 2'd0;
      active  <= 16'h0000;
      shadow  <= 16'h0000;
      pending <= 1'b0;
      ready   <= 1'b1;
      hex_out <= 4'h0;
      an      <= 4'hF;
    end else begin
      // A load on the boundary cycle can only be accepted when nothing is pending,
      // so it never collides with the commit below and lands one frame later.
      if (load && ready) begin
        shadow  <= data_in;
        pending <= 1'b1;
        ready   <= 1'b0;
      end

      case (state)
        BLANK: begin
          cnt <= cnt + CNT_W'(1);
          if (cnt == BLANK_LAST) begin
            state   <= ON;
            hex_out <= nib;
            an      <= supp[idx] ? 4'hF : ~(4'b0001 << idx);
          end
        end
        ON: begin
          if (cnt == SLOT_LAST) begin
            cnt   <= '0;
            idx   <= idx + 2'd1;
            state <= BLANK;
            an    <= 4'hF;
            // Frame boundary: swap in the shadow value so digit 0 of the
            // next frame already shows it; the panel never mixes two values.
            if (idx == 2'd3 && pending) begin
              active  <= shadow;
              pending <= 1'b0;
              ready   <= 1'b1;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= BLANK;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sevenseg_scan_ctrl.sv
// Bench for sevenseg_scan_ctrl with SLOT_CYCLES=8, BLANK_CYCLES=2 (32-cycle frame).
// Stimulus pushes per-slot expectations; a monitor pops one at the middle of every ON slot.
module tb_sevenseg_scan_ctrl;

  logic        clk;
  logic        rst_n;
  logic        load;
  logic [15:0] data_in;
  logic        lz_en;
  logic [3:0]  blank_mask;
  logic        ready;
  logic [3:0]  hex_out;
  logic [3:0]  an;

  int checks = 0;
  int errors = 0;
  int ph;

  typedef struct packed {
    logic [3:0] an;
    logic [3:0] hex;
    logic       rdy;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   mon_slot;

  sevenseg_scan_ctrl #(
    .SLOT_CYCLES (8),
    .BLANK_CYCLES(2),
    .CNT_W       (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .data_in   (data_in),
    .lz_en     (lz_en),
    .blank_mask(blank_mask),
    .ready     (ready),
    .hex_out   (hex_out),
    .an        (an)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycles since reset release; equals the DUT's position within the frame.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) ph <= 0;
    else        ph <= ph + 1;
  end

  // Monitor: blank phase must keep all anodes off; mid-ON sample is scoreboarded.
  always @(negedge clk) begin
    if (rst_n) begin
      if ((ph % 8) < 2) begin
        checks++;
        if (an !== 4'hF) begin
          errors++;
          $display("FAIL blank_an ph=%0d: got an=%b expected 1111", ph, an);
        end
      end
      if ((ph % 8) == 4 && q.size() > 0) begin
        mon_e    = q.pop_front();
        mon_slot = (ph / 8) % 4;
        checks++;
        if (an !== mon_e.an) begin
          errors++;
          $display("FAIL slot_an ph=%0d digit%0d: got %b expected %b", ph, mon_slot, an, mon_e.an);
        end
        checks++;
        if (hex_out !== mon_e.hex) begin
          errors++;
          $display("FAIL slot_hex ph=%0d digit%0d: got %h expected %h", ph, mon_slot, hex_out, mon_e.hex);
        end
        checks++;
        if (ready !== mon_e.rdy) begin
          errors++;
          $display("FAIL slot_ready ph=%0d digit%0d: got %b expected %b", ph, mon_slot, ready, mon_e.rdy);
        end
      end
    end
  end

  // Queue n slot expectations: lit[i]=1 means digit i lit, v holds the nibble on hex_out.
  task automatic push_slots(input logic [15:0] v, input logic [3:0] lit, input logic rdy, input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.an  = lit[i] ? ~(4'b0001 << i) : 4'hF;
      e.hex = v[4*i +: 4];
      e.rdy = rdy;
      q.push_back(e);
    end
  endtask

  task automatic push_frame(input logic [15:0] v, input logic [3:0] lit, input logic rdy);
    push_slots(v, lit, rdy, 4);
  endtask

  // Advance to the next negedge whose frame position is t (bounded).
  task automatic wait_to(input int t);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((ph % 32) != t && n < 64);
    if ((ph % 32) != t) begin
      checks++;
      errors++;
      $display("FAIL wait_to: got ph=%0d expected frame position %0d", ph, t);
    end
  endtask

  task automatic pulse_load(input logic [15:0] v);
    load    = 1'b1;
    data_in = v;
    @(negedge clk);
    load    = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n      = 1'b0;
    load       = 1'b0;
    data_in    = 16'h0000;
    lz_en      = 1'b0;
    blank_mask = 4'b0000;
    repeat (3) @(negedge clk);

    // Reset values
    checks++;
    if (an !== 4'hF || hex_out !== 4'h0 || ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_vals: got an=%b hex=%h ready=%b expected 1111 0 1", an, hex_out, ready);
    end
    rst_n = 1'b1;

    // 1: idle scan of zeros
    push_frame(16'h0000, 4'b1111, 1'b1);

    // 2: load 1234 at frame start; shows next frame
    wait_to(0);
    push_frame(16'h0000, 4'b1111, 1'b0);
    pulse_load(16'h1234);
    wait_to(0);
    push_frame(16'h1234, 4'b1111, 1'b1);

    // 3: load while pending is ignored; boundary-cycle load commits one frame later
    wait_to(0);
    push_frame(16'h1234, 4'b1111, 1'b0);
    pulse_load(16'h5678);
    wait_to(10);
    pulse_load(16'hFFFF);
    wait_to(0);
    push_frame(16'h5678, 4'b1111, 1'b1);
    wait_to(31);
    pulse_load(16'h0ABC);
    push_frame(16'h5678, 4'b1111, 1'b0);
    wait_to(0);
    push_frame(16'h0ABC, 4'b1111, 1'b1);

    // 4: leading-zero suppression
    wait_to(0);
    lz_en = 1'b1;
    push_frame(16'h0ABC, 4'b0111, 1'b0);
    pulse_load(16'h0050);
    wait_to(0);
    push_frame(16'h0050, 4'b0011, 1'b1);
    wait_to(0);
    push_frame(16'h0050, 4'b0011, 1'b0);
    pulse_load(16'h0000);
    wait_to(0);
    push_frame(16'h0000, 4'b0001, 1'b1);

    // 5: per-digit force blank
    wait_to(0);
    lz_en      = 1'b0;
    blank_mask = 4'b0101;
    push_frame(16'h0000, 4'b1010, 1'b0);
    pulse_load(16'hABCD);
    wait_to(0);
    push_frame(16'hABCD, 4'b1010, 1'b1);

    // 6: async reset mid-ON of digit 2 with a pending value
    wait_to(0);
    blank_mask = 4'b0000;
    push_slots(16'hABCD, 4'b1111, 1'b0, 2);
    pulse_load(16'h9999);
    wait_to(19);
    checks++;
    if (an !== 4'b1011 || hex_out !== 4'hB) begin
      errors++;
      $display("FAIL pre_reset: got an=%b hex=%h expected 1011 b", an, hex_out);
    end
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if (an !== 4'hF) begin
      errors++;
      $display("FAIL async_reset_an: got %b expected 1111", an);
    end
    checks++;
    if (hex_out !== 4'h0 || ready !== 1'b1) begin
      errors++;
      $display("FAIL async_reset_out: got hex=%h ready=%b expected 0 1", hex_out, ready);
    end
    @(negedge clk);
    @(negedge clk);
    #3 rst_n = 1'b1;
    push_frame(16'h0000, 4'b1111, 1'b1);
    wait_to(0);
    push_frame(16'h0000, 4'b1111, 1'b1);
    wait_to(31);
    @(negedge clk);

    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d entries left expected 0", q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sevenseg_scan_ctrl.md
Name: sevenseg_scan_ctrl

Overview:
- Time-multiplexes the shared hex-to-seven-segment encoder across a 4-digit common-anode display.
- Accepts a 16-bit value through a ready/load handshake.
- Commits new values only at frame boundaries, so the display never tears.
- Inserts a blanking gap between digit slots to suppress ghosting, and optionally suppresses leading zeros.
- Sits between the datapath producing the value and the encoder, whose 7-bit active-low segment output drives the panel directly.

Parameters:
SLOT_CYCLES, 100000, clock cycles per digit slot, blank plus on (1 ms at 100 MHz); must be >= 2.
BLANK_CYCLES, 1000, cycles at the start of each slot with all anodes off; must be >= 1 and < SLOT_CYCLES.
CNT_W, 17, slot counter width; must satisfy 2^CNT_W > SLOT_CYCLES.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  reset, asynchronous, active-low
load  input  1  request to display data_in; accepted only when ready=1
data_in  input  16  four hex nibbles; [3:0] is digit 0 (rightmost), [15:12] is digit 3
lz_en  input  1  leading-zero suppression enable, sampled live
blank_mask  input  4  per-digit force-blank, bit i blanks digit i, sampled live
ready  output  1  high when no committed value is pending
hex_out  output  4  nibble to the encoder input
an  output  4  active-low anode enables, an[i]=0 lights digit i

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low.
- Reset values: an=4'b1111, hex_out=4'h0, ready=1. Internally: active=16'h0000, pending=0, digit index idx=0, state=BLANK, cnt=0.
- Registers:
  - active: the value currently shown.
  - shadow: the accepted value awaiting commit.
  - pending flag; ready = ~pending, registered.
- FSM states: BLANK and ON. cnt counts 0..SLOT_CYCLES-1 in every slot.
  - BLANK: an=1111. When cnt=BLANK_CYCLES-1, go to ON.
  - ON: an[idx]=0, other anodes 1, unless digit idx is suppressed (see below), in which case an=1111. hex_out=active[4*idx+3 : 4*idx].
  - End of ON: when cnt=SLOT_CYCLES-1, cnt is cleared, idx advances 0→1→2→3→0, and the FSM goes to BLANK.
- Output timing: an and hex_out are registered and change on the same edge as the state and idx update. There is no combinational path from inputs to outputs.
- hex_out holds its last value during BLANK.
- Frame boundary: the edge ending the ON slot of idx=3. Frame length is 4*SLOT_CYCLES cycles.
- Handshake and commit:
  - When load=1 and ready=1, shadow<=data_in and pending<=1; ready reads 0 from the next cycle.
  - When load=1 and ready=0, the request is ignored and shadow is unchanged.
  - At a frame boundary with pending=1: active<=shadow, pending<=0, ready reads 1 from the next cycle. Digit 0 of the new frame shows the new value.
  - If a load is accepted on the frame-boundary cycle itself, it commits at the next boundary, not this one.
- Suppression: digit i is blanked when either condition holds:
  - blank_mask[i]=1, or
  - lz_en=1, i≠0, and active nibbles i through 3 are all zero.
  - Digit 0 is never zero-suppressed. Suppression is evaluated from live inputs and applied at ON entry.
- Mid-operation reset: all outputs return to their reset values immediately (asynchronous), pending is discarded, and active is cleared.

Test Plan:
All scenarios use SLOT_CYCLES=8 and BLANK_CYCLES=2.
1. Reset release with no load → repeating pattern an=1111×2, 1110×6, 1111×2, 1101×6, 1111×2, 1011×6, 1111×2, 0111×6 (32-cycle frame); hex_out=0 throughout; ready=1.
2. load=1, data_in=16'h1234 during frame N → ready=0 next cycle; frame N still shows 0; frame N+1 shows hex_out 4,3,2,1 on an 1110,1101,1011,0111; ready=1 the cycle after the boundary.
3. With pending set, pulse load with 16'hFFFF → ignored; the committed value is 16'h1234. A load on the exact boundary cycle commits one frame later.
4. lz_en=1, value 16'h0050 → digits 3 and 2 show an=1111 through their ON slots; digit 1 shows 5; digit 0 shows 0. Value 16'h0000 → only digit 0 lights, showing 0.
5. blank_mask=4'b0101, value 16'hABCD, lz_en=0 → digits 0 and 2 dark; digit 1 shows C, digit 3 shows A.
6. Assert rst_n=0 mid-ON of digit 2 with a pending load → an=1111 asynchronously; after release ready=1, display shows 0, and the pending value is never displayed.
